// File: rtl/bl_wl_config_loader_pkg.sv
// Shared types and sizing helpers for the bit-line/word-line configuration loader.
package config_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } cfg_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bl_wl_config_loader_if.sv
// Valid/ready byte stream carrying the configuration bitstream into the loader.
interface bl_wl_config_loader_if #(
    parameter int IN_W = 8
);
    logic [IN_W-1:0] s_data;
    logic            s_valid;
    logic            s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bl_wl_config_loader_row_assembler.sv
// Collects stream beats into one word-line row, LSB first; bits past NUM_BL are dropped.
module cfg_row_assembler
    import config_loader_pkg::*;
#(
    parameter int NUM_BL = 8,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IN_W-1:0]   beat,
    output logic [NUM_BL-1:0] shadow_nxt,
    output logic              row_full
);
    localparam int BEATS = ceil_div(NUM_BL, IN_W);
    localparam int BW    = cnt_w(BEATS);

    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [NUM_BL-1:0] shadow_q, shadow_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        shadow_d   = shadow_q;
        row_full   = 1'b0;
        if (clr) begin
            beat_cnt_d = '0;
        end else if (wr_en) begin
            // Each row bit belongs to exactly one beat, so indices stay in range.
            for (int i = 0; i < NUM_BL; i++) begin
                if (beat_cnt_q == BW'(i / IN_W))
                    shadow_d[i] = beat[i % IN_W];
            end
            if (beat_cnt_q == BW'(BEATS - 1)) begin
                row_full   = 1'b1;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            shadow_q   <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            shadow_q   <= shadow_d;
        end
    end

    assign shadow_nxt = shadow_d;

endmodule

// File: rtl/bl_wl_config_loader.sv
// Loads NUM_WL rows of NUM_BL bits into a tile: bl set up, wl pulsed one-hot, bl held.
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   FILL  | accepting beats of the current row
//   SETUP | bl driven, wl low
//   PULSE | wl[row] high for WL_PULSE cycles
//   HOLD  | wl low, bl held, then next row or finish
//   DONE  | one cycle with done and busy both high
module bl_wl_config_loader
    import config_loader_pkg::*;
#(
    parameter int NUM_BL   = 8,
    parameter int NUM_WL   = 8,
    parameter int IN_W     = 8,
    parameter int WL_PULSE = 2
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 start,
    bl_wl_config_loader_if.slave s,
    output logic [NUM_BL-1:0]    bl,
    output logic [NUM_WL-1:0]    wl,
    output logic                 busy,
    output logic                 done
);
    localparam int RW = cnt_w(NUM_WL);
    localparam int PW = cnt_w(WL_PULSE);

    cfg_state_e        state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [NUM_BL-1:0] bl_q, bl_d;
    logic [NUM_WL-1:0] wl_q, wl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              s_ready_q, s_ready_d;

    logic              beat_clr;
    logic              wr_en;
    logic              row_full;
    logic [NUM_BL-1:0] shadow_nxt;

    assign wr_en = s.s_valid & s_ready_q;

    cfg_row_assembler #(
        .NUM_BL (NUM_BL),
        .IN_W   (IN_W)
    ) u_row_asm (
        .clk        (prog_clk),
        .rst        (prog_reset),
        .clr        (beat_clr),
        .wr_en      (wr_en),
        .beat       (s.s_data),
        .shadow_nxt (shadow_nxt),
        .row_full   (row_full)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        pcnt_d   = pcnt_q;
        bl_d     = bl_q;
        wl_d     = wl_q;
        done_d   = done_q;
        beat_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                bl_d = '0;
                wl_d = '0;
                if (start) begin
                    state_d  = FILL;
                    done_d   = 1'b0;
                    row_d    = '0;
                    beat_clr = 1'b1;
                end
            end
            FILL: begin
                // bl is loaded with the row including the beat landing this edge.
                if (row_full) begin
                    bl_d    = shadow_nxt;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                for (int i = 0; i < NUM_WL; i++)
                    wl_d[i] = (row_q == RW'(i));
                pcnt_d  = '0;
                state_d = PULSE;
            end
            PULSE: begin
                if (pcnt_q == PW'(WL_PULSE - 1)) begin
                    wl_d    = '0;
                    state_d = HOLD;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            HOLD: begin
                bl_d = '0;
                if (row_q == RW'(NUM_WL - 1)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    row_d    = row_q + RW'(1);
                    beat_clr = 1'b1;
                    state_d  = FILL;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == FILL);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            pcnt_q    <= '0;
            bl_q      <= '0;
            wl_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            pcnt_q    <= pcnt_d;
            bl_q      <= bl_d;
            wl_q      <= wl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s.s_ready = s_ready_q;
    assign bl        = bl_q;
    assign wl        = wl_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bl_wl_config_loader.sv
// Scoreboard bench: stimulus pushes expected row pulses, a negedge monitor pops and compares.
module tb_bl_wl_config_loader;

    logic prog_clk = 1'b0;
    logic prog_reset;
    logic start_a, start_b;

    always #5 prog_clk = ~prog_clk;

    bl_wl_config_loader_if #(.IN_W(8)) if_a ();
    bl_wl_config_loader_if #(.IN_W(8)) if_b ();

    logic [7:0]  bl_a, wl_a;
    logic        busy_a, done_a;
    logic [11:0] bl_b;
    logic [1:0]  wl_b;
    logic        busy_b, done_b;

    bl_wl_config_loader dut_a (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start_a),
        .s          (if_a),
        .bl         (bl_a),
        .wl         (wl_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    bl_wl_config_loader #(.NUM_BL(12), .NUM_WL(2), .IN_W(8), .WL_PULSE(2)) dut_b (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start_b),
        .s          (if_b),
        .bl         (bl_b),
        .wl         (wl_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    typedef struct packed {
        logic [15:0] wl;
        logic [15:0] bl;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit abort_a = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor / scoreboard
    logic [15:0] m_wl[2], m_bl[2], p_wl[2], p_bl[2];
    int          plen[2];
    exp_t        e;
    initial begin
        for (int c = 0; c < 2; c++) begin
            p_wl[c] = '0; p_bl[c] = '0; plen[c] = 0;
        end
    end

    always @(negedge prog_clk) begin
        m_wl[0] = 16'(wl_a); m_bl[0] = 16'(bl_a);
        m_wl[1] = 16'(wl_b); m_bl[1] = 16'(bl_b);
        for (int c = 0; c < 2; c++) begin
            if (m_wl[c] != 0)
                check($sformatf("bl_stable_ch%0d", c), m_bl[c], p_bl[c]);
            if (m_wl[c] != 0 && p_wl[c] == 0) begin
                if ((c == 0 && q_a.size() == 0) || (c == 1 && q_b.size() == 0)) begin
                    timeout_fail($sformatf("unexpected_pulse_ch%0d wl=%0h", c, m_wl[c]));
                end else begin
                    e = (c == 0) ? q_a.pop_front() : q_b.pop_front();
                    check($sformatf("wl_row_ch%0d", c), m_wl[c], e.wl);
                    check($sformatf("bl_row_ch%0d", c), m_bl[c], e.bl);
                end
                plen[c] = 1;
            end else if (m_wl[c] != 0) begin
                check($sformatf("wl_steady_ch%0d", c), m_wl[c], p_wl[c]);
                plen[c]++;
            end else if (p_wl[c] != 0) begin
                if (c == 0 && abort_a) abort_a = 1'b0;
                else check($sformatf("pulse_len_ch%0d", c), plen[c], 2);
            end
            p_wl[c] = m_wl[c];
            p_bl[c] = m_bl[c];
        end
    end

    task automatic send_beat(input int which, input logic [7:0] d, input int gap);
        int t;
        repeat (gap) @(negedge prog_clk);
        t = 0;
        if (which == 0) begin
            if_a.s_data = d; if_a.s_valid = 1'b1;
            while (!if_a.s_ready && t < 200) begin @(negedge prog_clk); t++; end
        end else begin
            if_b.s_data = d; if_b.s_valid = 1'b1;
            while (!if_b.s_ready && t < 200) begin @(negedge prog_clk); t++; end
        end
        if (t >= 200) timeout_fail("beat_accept");
        @(negedge prog_clk);
        if_a.s_valid = 1'b0;
        if_b.s_valid = 1'b0;
    endtask

    task automatic wait_done(input int which, input int maxc);
        int t = 0;
        while (!((which == 0) ? done_a : done_b) && t < maxc) begin
            @(negedge prog_clk); t++;
        end
        if (t >= maxc) timeout_fail("wait_done");
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge prog_clk);
        start_a = 1'b0;
    endtask

    task automatic push_a(input int r, input logic [7:0] d);
        q_a.push_back('{wl: 16'(8'(1) << r), bl: 16'(d)});
    endtask

    initial begin
        int cyc;
        logic [17:0] snap;
        logic [7:0] d;
        prog_reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        if_a.s_valid = 1'b0; if_a.s_data = '0;
        if_b.s_valid = 1'b0; if_b.s_data = '0;
        repeat (3) @(negedge prog_clk);
        check("reset_a", {if_a.s_ready, bl_a, wl_a, busy_a, done_a}, '0);
        check("reset_b", {if_b.s_ready, bl_b, wl_b, busy_b, done_b}, '0);
        prog_reset = 1'b0;
        @(negedge prog_clk);

        // Stall-free defaults: row r carries 1<<r; done 42 cycles from start.
        for (int r = 0; r < 8; r++) push_a(r, 8'(1) << r);
        start_a = 1'b1;
        cyc = 1;
        fork
            begin
                @(negedge prog_clk);
                start_a = 1'b0;
                check("start_busy", {busy_a, if_a.s_ready}, 2'b11);
                for (int r = 0; r < 8; r++) send_beat(0, 8'(1) << r, 0);
            end
            begin
                while (!done_a && cyc < 500) begin @(negedge prog_clk); cyc++; end
            end
        join
        check("done_cycles", cyc, 42);
        check("done_with_busy", busy_a, 1'b1);
        @(negedge prog_clk);
        check("done_sticky_idle", {busy_a, done_a}, 2'b01);

        // s_valid in IDLE without start consumes nothing and moves nothing.
        snap = {bl_a, wl_a, busy_a, done_a};
        if_a.s_valid = 1'b1; if_a.s_data = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge prog_clk);
            check("idle_ready", if_a.s_ready, 1'b0);
            check("idle_quiet", {bl_a, wl_a, busy_a, done_a}, snap);
        end
        if_a.s_valid = 1'b0;

        // Random gaps: identical bl/wl sequence.
        for (int r = 0; r < 8; r++) push_a(r, 8'(1) << r);
        pulse_start_a();
        for (int r = 0; r < 8; r++) send_beat(0, 8'(1) << r, $urandom_range(0, 5));
        wait_done(0, 200);
        @(negedge prog_clk);

        // start during row 3 FILL and during its PULSE is ignored.
        for (int r = 0; r < 8; r++) push_a(r, 8'hC3 ^ 8'(r));
        pulse_start_a();
        for (int r = 0; r < 8; r++) begin
            d = 8'hC3 ^ 8'(r);
            if (r == 3) begin
                cyc = 0;
                while (!if_a.s_ready && cyc < 50) begin @(negedge prog_clk); cyc++; end
                pulse_start_a();
                check("start_in_fill", {busy_a, if_a.s_ready, done_a}, 3'b110);
                send_beat(0, d, 0);
                @(negedge prog_clk);
                check("in_pulse_row3", wl_a, 8'h08);
                pulse_start_a();
                check("start_in_pulse", {busy_a, done_a, wl_a}, {2'b10, 8'h08});
            end else begin
                send_beat(0, d, 0);
            end
        end
        wait_done(0, 200);
        @(negedge prog_clk);
        check("done_after_busy_starts", {busy_a, done_a}, 2'b01);

        // Restart clears done; reset during row 5 PULSE aborts.
        pulse_start_a();
        check("restart_clears_done", {busy_a, done_a}, 2'b10);
        for (int r = 0; r < 6; r++) push_a(r, 8'h5A + 8'(r));
        for (int r = 0; r < 6; r++) send_beat(0, 8'h5A + 8'(r), 0);
        @(negedge prog_clk);
        check("row5_pulse", {wl_a, bl_a}, {8'h20, 8'h5F});
        abort_a = 1'b1;
        prog_reset = 1'b1;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        check("mid_reset", {if_a.s_ready, bl_a, wl_a, busy_a, done_a}, '0);
        @(negedge prog_clk);

        // Fresh load after reset starts at row 0.
        for (int r = 0; r < 8; r++) push_a(r, 8'h80 >> r);
        pulse_start_a();
        for (int r = 0; r < 8; r++) send_beat(0, 8'h80 >> r, r % 2);
        wait_done(0, 200);
        @(negedge prog_clk);

        // 12-bit rows from two beats each; upper nibble of the second beat dropped.
        q_b.push_back('{wl: 16'h0001, bl: 16'h0CAB});
        q_b.push_back('{wl: 16'h0002, bl: 16'h0534});
        start_b = 1'b1;
        cyc = 1;
        fork
            begin
                @(negedge prog_clk);
                start_b = 1'b0;
                send_beat(1, 8'hAB, 0);
                send_beat(1, 8'hFC, 0);
                send_beat(1, 8'h34, 0);
                send_beat(1, 8'hF5, 0);
            end
            begin
                while (!done_b && cyc < 500) begin @(negedge prog_clk); cyc++; end
            end
        join
        check("done_cycles_b", cyc, 14);
        repeat (3) @(negedge prog_clk);
        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
